// File: rtl/fp_pkg.sv
// Shared floating-point constants and the normalizer state encoding.
// Used by both the adder stage and the normalizer.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int EXP_BIAS  = 127;
  localparam int EXP_MAX   = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SHIFT,
    ST_DONE
  } norm_state_e;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic underflow;
  } norm_flags_t;

endpackage

// File: rtl/fp_normalize.sv
// Normalizes a raw adder sum into an IEEE-754 single; 2 cycles to ready, plus 1 per left shift.
// No backpressure: start is only taken in IDLE/DONE, and the result holds until the next accept.
module fp_normalize
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W+1:0] mant_i,
  output logic             busy,
  output logic             ready,
  output logic [31:0]      data_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int SUM_W = MAN_W + 2;
  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);

  norm_state_e      state_q;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [SUM_W-1:0] mant_q;
  logic [RES_W-1:0] res_q;
  norm_flags_t      flags_q;
  logic [RES_W-1:0] out_q;
  norm_flags_t      out_flags_q;
  logic             busy_q;
  logic             ready_q;

  logic [EXP_W-1:0] exp_inc_d;
  logic [EXP_W-1:0] exp_dec_d;
  logic [SUM_W-1:0] mant_shl_d;

  assign exp_inc_d  = exp_q + EXP_W'(1);
  assign exp_dec_d  = exp_q - EXP_W'(1);
  assign mant_shl_d = mant_q << 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      out_q       <= '0;
      out_flags_q <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sign_q  <= sign_i;
            exp_q   <= exp_i;
            mant_q  <= mant_i;
            res_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
          if (exp_q == EXP_ALL1) begin
            res_q <= {sign_q, exp_q, mant_q[MAN_W-1:0]};
          end else if (mant_q == '0) begin
            flags_q.zero <= 1'b1;
          end else if (exp_q == '0) begin
            res_q             <= {sign_q, {(RES_W-1){1'b0}}};
            flags_q.underflow <= 1'b1;
          end else if (mant_q[MAN_W+1]) begin
            if (exp_inc_d == EXP_ALL1) begin
              res_q            <= {sign_q, EXP_ALL1, {MAN_W{1'b0}}};
              flags_q.overflow <= 1'b1;
            end else begin
              res_q <= {sign_q, exp_inc_d, mant_q[MAN_W:1]};
            end
          end else if (mant_q[MAN_W]) begin
            res_q <= {sign_q, exp_q, mant_q[MAN_W-1:0]};
          end else begin
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          mant_q <= mant_shl_d;
          exp_q  <= exp_dec_d;
          // Reaching exponent 0 wins over normalizing on the same step: no denormals.
          if (exp_dec_d == '0) begin
            res_q             <= {sign_q, {(RES_W-1){1'b0}}};
            flags_q.underflow <= 1'b1;
            busy_q            <= 1'b0;
            state_q           <= ST_DONE;
          end else if (mant_shl_d[MAN_W]) begin
            res_q   <= {sign_q, exp_dec_d, mant_shl_d[MAN_W-1:0]};
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Output stage lags DONE entry by one edge and is zeroed on the accepting edge.
      if (state_q == ST_DONE && !start) begin
        ready_q     <= 1'b1;
        out_q       <= res_q;
        out_flags_q <= flags_q;
      end else begin
        ready_q     <= 1'b0;
        out_q       <= '0;
        out_flags_q <= '0;
      end
    end
  end

  assign busy        = busy_q;
  assign ready       = ready_q;
  assign data_o      = 32'(out_q);
  assign zero_o      = out_flags_q.zero;
  assign overflow_o  = out_flags_q.overflow;
  assign underflow_o = out_flags_q.underflow;

endmodule

// File: tb/tb_fp_normalize.sv
// Bench for fp_normalize: directed corner cases plus randomized operands against a closed-form model.
module tb_fp_normalize;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [24:0] mant_i;
  logic        busy;
  logic        ready;
  logic [31:0] data_o;
  logic        zero_o;
  logic        overflow_o;
  logic        underflow_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clock = ~clock;

  fp_normalize #(.EXP_W(8), .MAN_W(23)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .sign_i     (sign_i),
    .exp_i      (exp_i),
    .mant_i     (mant_i),
    .busy       (busy),
    .ready      (ready),
    .data_o     (data_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  // Expected result from the field rules; lat counts edges from accept to ready.
  task automatic model(input logic s, input logic [7:0] e, input logic [24:0] m,
                       output logic [31:0] d, output logic [2:0] f, output int lat);
    int lead, need, ev;
    logic [24:0] sh;
    lead = -1; d = '0; f = 3'b000; lat = 2; ev = int'(e);
    if (ev == 255) d = {s, e, m[22:0]};
    else if (m == 25'd0) f = 3'b100;
    else if (ev == 0) begin d = {s, 31'd0}; f = 3'b001; end
    else if (m[24]) begin
      if (ev + 1 == 255) begin d = {s, 8'hFF, 23'd0}; f = 3'b010; end
      else d = {s, 8'(ev + 1), m[23:1]};
    end else if (m[23]) d = {s, e, m[22:0]};
    else begin
      for (int i = 0; i < 23; i++) if (m[i]) lead = i;
      need = 23 - lead;
      if (need >= ev) begin d = {s, 31'd0}; f = 3'b001; lat = 2 + ev; end
      else begin
        sh = m << need;
        d = {s, 8'(ev - need), sh[22:0]};
        lat = 2 + need;
      end
    end
  endtask

  // Issues one request and waits (bounded) for ready; lat = -1 if it never came.
  task automatic do_op(input logic s, input logic [7:0] e, input logic [24:0] m,
                       output int lat, output logic [31:0] d, output logic [2:0] f,
                       output logic busy_k, output logic ready_k);
    @(negedge clock);
    sign_i = s; exp_i = e; mant_i = m; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; busy_k = busy; ready_k = ready;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (ready) begin lat = i; break; end
    end
    d = data_o; f = {zero_o, overflow_o, underflow_o};
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; sign_i = 1'b0; exp_i = '0; mant_i = '0;
    repeat (2) @(negedge clock);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", data_o); else pass_cnt++;
    chk_cnt++;
    if ({zero_o, overflow_o, underflow_o} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {zero_o, overflow_o, underflow_o});
    else pass_cnt++;
    reset = 1'b1;
  endtask

  task automatic test_directed;
    logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  ve [5] = '{8'd127, 8'd130, 8'd100, 8'd254, 8'd2};
    logic [24:0] vm [5] = '{25'h1800000, 25'h0200000, 25'h0, 25'h1000000, 25'h0000001};
    logic [31:0] xd [5] = '{32'h40400000, 32'h40000000, 32'h0, 32'h7F800000, 32'h80000000};
    logic [2:0]  xf [5] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001};
    int          xl [5] = '{2, 4, 2, 2, 4};
    int lat; logic [31:0] d; logic [2:0] f; logic bk, rk;
    for (int i = 0; i < 5; i++) begin
      do_op(vs[i], ve[i], vm[i], lat, d, f, bk, rk);
      chk_cnt++; if (bk !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", i, bk); else pass_cnt++;
      chk_cnt++; if (lat != xl[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, xl[i]); else pass_cnt++;
      chk_cnt++; if (d !== xd[i]) $display("FAIL dir%0d_data: got %h want %h", i, d, xd[i]); else pass_cnt++;
      chk_cnt++; if (f !== xf[i]) $display("FAIL dir%0d_flags: got %b want %b", i, f, xf[i]); else pass_cnt++;
    end
  endtask

  task automatic test_hold_stable;
    int lat; logic [31:0] d; logic [2:0] f; logic bk, rk;
    do_op(1'b1, 8'd140, 25'h0C00000, lat, d, f, bk, rk);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk_cnt++;
      if (ready !== 1'b1 || data_o !== 32'hC6400000)
        $display("FAIL hold%0d: got ready=%b data=%h want ready=1 data=c6400000", i, ready, data_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    int lat, xlat, cls, lead; logic [31:0] d, xd; logic [2:0] f, xf; logic bk, rk;
    logic s; logic [7:0] e; logic [24:0] m;
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 5);
      s = 1'($urandom_range(0, 1)); e = 8'($urandom_range(1, 254)); m = 25'($urandom);
      case (cls)
        0: e = 8'hFF;
        1: m = 25'd0;
        2: begin e = 8'd0; m[0] = 1'b1; end
        3: begin m[24] = 1'b1; if ($urandom_range(0, 3) == 0) e = 8'd254; end
        4: begin m[24] = 1'b0; m[23] = 1'b1; end
        default: begin
          lead = $urandom_range(0, 22);
          m = m & ((25'd1 << (lead + 1)) - 25'd1);
          m[lead] = 1'b1;
          if ($urandom_range(0, 2) == 0) e = 8'($urandom_range(1, 25));
        end
      endcase
      model(s, e, m, xd, xf, xlat);
      do_op(s, e, m, lat, d, f, bk, rk);
      chk_cnt++; if (rk !== 1'b0) $display("FAIL rnd%0d_ready_drop: got %b want 0", n, rk); else pass_cnt++;
      chk_cnt++; if (lat != xlat) $display("FAIL rnd%0d_latency: got %0d want %0d", n, lat, xlat); else pass_cnt++;
      chk_cnt++; if (d !== xd) $display("FAIL rnd%0d_data: got %h want %h (in %b %h %h)", n, d, xd, s, e, m); else pass_cnt++;
      chk_cnt++; if (f !== xf) $display("FAIL rnd%0d_flags: got %b want %b", n, f, xf); else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start;
    int lat, xlat; logic [31:0] xd; logic [2:0] xf;
    model(1'b0, 8'd150, 25'h0000100, xd, xf, xlat);
    @(negedge clock);
    sign_i = 1'b0; exp_i = 8'd150; mant_i = 25'h0000100; start = 1'b1;
    @(posedge clock); #1;
    sign_i = 1'b1; exp_i = 8'hFF; mant_i = 25'h1FFFFFF;
    repeat (5) @(posedge clock);
    #1 start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (ready) begin lat = 5 + i; break; end
    end
    chk_cnt++; if (lat != xlat) $display("FAIL ignore_latency: got %0d want %0d", lat, xlat); else pass_cnt++;
    chk_cnt++; if (data_o !== xd) $display("FAIL ignore_data: got %h want %h", data_o, xd); else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift;
    int lat; logic [31:0] d; logic [2:0] f; logic bk, rk;
    @(negedge clock);
    sign_i = 1'b0; exp_i = 8'd200; mant_i = 25'h0000001; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL midshift_busy_before: got %b want 1", busy); else pass_cnt++;
    #1 reset = 1'b0;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL midshift_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (ready !== 1'b0) $display("FAIL midshift_ready: got %b want 0", ready); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h0) $display("FAIL midshift_data: got %h want 0", data_o); else pass_cnt++;
    @(negedge clock) reset = 1'b1;
    do_op(1'b0, 8'd127, 25'h1800000, lat, d, f, bk, rk);
    chk_cnt++; if (lat != 2) $display("FAIL after_reset_latency: got %0d want 2", lat); else pass_cnt++;
    chk_cnt++; if (d !== 32'h40400000) $display("FAIL after_reset_data: got %h want 40400000", d); else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_hold_stable();
    test_random();
    test_ignore_start();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-fraction width; raw sum width is MAN_W+2.
REQ-003 SHALL have port clock  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request; captures operand fields when accepted.
REQ-006 SHALL have port sign_i  in  1  raw result sign.
REQ-007 SHALL have port exp_i  in  EXP_W  raw biased exponent, pre-normalization.
REQ-008 SHALL have port mant_i  in  MAN_W+2  raw sum: bit 24 = carry, bit 23 = hidden one, bits 22:0 = fraction.
REQ-009 SHALL have port busy  out  1  high while normalizing.
REQ-010 SHALL have port ready  out  1  high while data_o holds a valid result.
REQ-011 SHALL have port data_o  out  32  IEEE-754 single result.
REQ-012 SHALL have ports zero_o, overflow_o, underflow_o  out  1 each  result flags, valid when ready=1.

Function
REQ-013 SHALL implement states IDLE, CHECK, SHIFT, DONE; busy=1 in CHECK and SHIFT only; ready=1 in DONE only.
REQ-014 SHALL, in IDLE or DONE with start=1 at an edge, register sign_i/exp_i/mant_i and enter CHECK; start SHALL be ignored in CHECK and SHIFT.
REQ-015 SHALL, in CHECK with exp=255, pass the exponent and mant[22:0] through unchanged (Inf/NaN) and enter DONE.
REQ-016 SHALL, in CHECK with mant=0, produce +0 (0x00000000), set zero_o, and enter DONE.
REQ-017 SHALL, in CHECK with exp=0 and mant nonzero, flush to signed zero, set underflow_o, and enter DONE.
REQ-018 SHALL, in CHECK with mant[24]=1, output fraction mant[23:1] (truncate bit 0) and exp+1; if exp+1=255, output signed infinity (fraction 0) with overflow_o=1; then enter DONE.
REQ-019 SHALL, in CHECK with mant[24]=0 and mant[23]=1, output the fields unchanged and enter DONE.
REQ-020 SHALL, otherwise, enter SHIFT; each SHIFT cycle SHALL shift mant left 1 and decrement exp by 1.
REQ-021 SHALL leave SHIFT for DONE when the shifted mant[23]=1, or when exp would reach 0; in the latter case it SHALL flush to signed zero with underflow_o=1.
REQ-022 SHALL have latency: start accepted at edge k gives ready=1 after edge k+2 for CHECK-terminated cases and after edge k+2+n for n shift cycles; n SHALL be at most 23.
REQ-023 SHALL drive data_o and the flags from registers; they SHALL read 0 whenever ready=0 and SHALL hold stable throughout DONE.
REQ-024 SHALL clear every flag on each new accept.

Reset
REQ-025 SHALL, while reset=0, force state IDLE, clear all internal registers, and drive busy=0, ready=0, data_o=0 and flags=0, including mid-SHIFT.
REQ-026 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-027 SHALL place the state encoding, EXP_BIAS=127, EXP_MAX=255 and field-width constants in shared package fp_pkg, reused by the adder stage.
REQ-028 SHALL be a single module with no sub-module; the iterative shifter makes a leading-zero counter unnecessary.

Verification
REQ-029 SHALL check: sign=0, exp=127, mant=0x1800000 -> data_o=0x40400000, ready two edges after start.
REQ-030 SHALL check: exp=130, mant=0x0200000 -> two shifts, data_o=0x40000000, ready at k+4.
REQ-031 SHALL check: mant=0 -> data_o=0x00000000, zero_o=1.
REQ-032 SHALL check: sign=0, exp=254, mant=0x1000000 -> data_o=0x7F800000, overflow_o=1.
REQ-033 SHALL check: sign=1, exp=2, mant=0x0000001 -> data_o=0x80000000, underflow_o=1.
REQ-034 SHALL check: reset pulled low during SHIFT -> busy=0, ready=0, data_o=0 immediately; a new start after release completes correctly.
